id_ex_latch: RTL and testbench

- ID/EX pipeline register directly downstream of the decode-stage register bank.
- Captures the two register read operands, the sign-extended immediate, register addresses, PC+4 and the decode control bundle.
- Presents these to the execute stage.
- Contains the load-use hazard detector: stalls PC/IF-ID and injects a bubble into EX.
- Honours the debug-unit enable (step mode) and branch/jump flush.

---
 rtl/id_ex_latch.sv | 113 +++++++++++
 tb/tb_id_ex_latch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use hazard detection. Latency 1 cycle; o_stall is combinational.
// i_enable=0 freezes the stage; flush, stall or an invalid IF/ID slot inject a bubble. ID_EX_WB_BYPASS_EN forwards writeback data into captured operands.
module id_ex_latch #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_CTRL = 12
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data_ra,
  input  logic [NB_DATA-1:0] i_data_rb,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [NB_DATA-1:0] i_pc4,
  input  logic [NB_REG-1:0]  i_rs,
  input  logic [NB_REG-1:0]  i_rt,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic               i_wb_we,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  output logic               o_stall,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data_ra,
  output logic [NB_DATA-1:0] o_data_rb,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_DATA-1:0] o_pc4,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_rd,
  output logic [NB_CTRL-1:0] o_ctrl
);

  typedef struct packed {
    logic               valid;
    logic [NB_DATA-1:0] data_ra;
    logic [NB_DATA-1:0] data_rb;
    logic [NB_DATA-1:0] imm;
    logic [NB_DATA-1:0] pc4;
    logic [NB_REG-1:0]  rs;
    logic [NB_REG-1:0]  rt;
    logic [NB_REG-1:0]  rd;
    logic [NB_CTRL-1:0] ctrl;
  } ex_t;

  ex_t ex_q;
  ex_t ex_d;
  logic [NB_DATA-1:0] op_ra;
  logic [NB_DATA-1:0] op_rb;

  // Load in EX whose destination feeds the instruction in ID; a taken flush squashes ID anyway.
  always_comb begin
    o_stall = ex_q.valid & ex_q.ctrl[1] & (ex_q.rt != '0) & i_valid &
              ((ex_q.rt == i_rs) | (ex_q.rt == i_rt)) & ~i_flush;
  end

`ifdef ID_EX_WB_BYPASS_EN
  always_comb begin
    op_ra = i_data_ra;
    op_rb = i_data_rb;
    if (i_wb_we && (i_wb_addr != '0) && (i_wb_addr == i_rs)) op_ra = i_wb_data;
    if (i_wb_we && (i_wb_addr != '0) && (i_wb_addr == i_rt)) op_rb = i_wb_data;
  end
`else
  logic wb_unused;
  always_comb begin
    op_ra     = i_data_ra;
    op_rb     = i_data_rb;
    wb_unused = ^{i_wb_we, i_wb_addr, i_wb_data};
  end
`endif

  always_comb begin
    ex_d = ex_q;
    if (!i_enable) begin
      ex_d = ex_q;
    end else if (i_flush || o_stall || !i_valid) begin
      // Bubble keeps the data fields; only ctrl and valid are cleared.
      ex_d.ctrl  = '0;
      ex_d.valid = 1'b0;
    end else begin
      ex_d.valid   = 1'b1;
      ex_d.data_ra = op_ra;
      ex_d.data_rb = op_rb;
      ex_d.imm     = i_imm;
      ex_d.pc4     = i_pc4;
      ex_d.rs      = i_rs;
      ex_d.rt      = i_rt;
      ex_d.rd      = i_rd;
      ex_d.ctrl    = i_ctrl;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) ex_q <= '0;
    else         ex_q <= ex_d;
  end

  always_comb begin
    o_valid   = ex_q.valid;
    o_data_ra = ex_q.data_ra;
    o_data_rb = ex_q.data_rb;
    o_imm     = ex_q.imm;
    o_pc4     = ex_q.pc4;
    o_rs      = ex_q.rs;
    o_rt      = ex_q.rt;
    o_rd      = ex_q.rd;
    o_ctrl    = ex_q.ctrl;
  end

endmodule

// File: tb/tb_id_ex_latch.sv
// Scoreboard bench for id_ex_latch: driver pushes expected stall/outputs per cycle, monitor compares at negedge.
module tb_id_ex_latch;
  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int NB_CTRL = 12;
  localparam int CAP = 0, BUB = 1, HOLD = 2, RST = 3;
`ifdef ID_EX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               i_clock = 1'b0;
  logic               i_reset, i_enable, i_flush, i_valid, i_wb_we;
  logic [NB_DATA-1:0] i_data_ra, i_data_rb, i_imm, i_pc4, i_wb_data;
  logic [NB_REG-1:0]  i_rs, i_rt, i_rd, i_wb_addr;
  logic [NB_CTRL-1:0] i_ctrl;
  logic               o_stall, o_valid;
  logic [NB_DATA-1:0] o_data_ra, o_data_rb, o_imm, o_pc4;
  logic [NB_REG-1:0]  o_rs, o_rt, o_rd;
  logic [NB_CTRL-1:0] o_ctrl;

  id_ex_latch #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_CTRL(NB_CTRL)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_valid(i_valid), .i_data_ra(i_data_ra), .i_data_rb(i_data_rb), .i_imm(i_imm),
    .i_pc4(i_pc4), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_ctrl(i_ctrl),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_stall(o_stall), .o_valid(o_valid), .o_data_ra(o_data_ra), .o_data_rb(o_data_rb),
    .o_imm(o_imm), .o_pc4(o_pc4), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_ctrl(o_ctrl)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic               reset, enable, flush, valid, wb_we;
    logic [NB_DATA-1:0] ra, rb, imm, pc4, wb_data;
    logic [NB_REG-1:0]  rs, rt, rd, wb_addr;
    logic [NB_CTRL-1:0] ctrl;
  } in_t;

  typedef struct {
    int                 idx;
    logic               stall, valid, chk_data;
    logic [NB_DATA-1:0] ra, rb, imm, pc4;
    logic [NB_REG-1:0]  rs, rt, rd;
    logic [NB_CTRL-1:0] ctrl;
  } exp_t;

  exp_t sb[$];
  in_t  cur;
  exp_t st;
  int   vec_idx = 0;
  bit   drv_done = 1'b0;
  logic               ov_ra_en = 1'b0, ov_rb_en = 1'b0;
  logic [NB_DATA-1:0] ov_ra = '0, ov_rb = '0;
  int   checks = 0;
  int   errors = 0;

  task automatic apply();
    i_reset = cur.reset; i_enable = cur.enable; i_flush = cur.flush; i_valid = cur.valid;
    i_data_ra = cur.ra; i_data_rb = cur.rb; i_imm = cur.imm; i_pc4 = cur.pc4;
    i_rs = cur.rs; i_rt = cur.rt; i_rd = cur.rd; i_ctrl = cur.ctrl;
    i_wb_we = cur.wb_we; i_wb_addr = cur.wb_addr; i_wb_data = cur.wb_data;
  endtask

  // Drive one cycle of inputs; mode and stall are the hand-derived outcome for this vector.
  task automatic step(input int mode, input logic exp_stall);
    exp_t e;
    @(posedge i_clock);
    #2;
    apply();
    case (mode)
      CAP: begin
        st.valid = 1'b1; st.chk_data = 1'b1;
        st.ra = ov_ra_en ? ov_ra : cur.ra;
        st.rb = ov_rb_en ? ov_rb : cur.rb;
        st.imm = cur.imm; st.pc4 = cur.pc4;
        st.rs = cur.rs; st.rt = cur.rt; st.rd = cur.rd; st.ctrl = cur.ctrl;
      end
      BUB: begin
        st.valid = 1'b0; st.ctrl = '0; st.chk_data = 1'b0;
      end
      RST: begin
        st.valid = 1'b0; st.ctrl = '0; st.chk_data = 1'b1;
        st.ra = '0; st.rb = '0; st.imm = '0; st.pc4 = '0;
        st.rs = '0; st.rt = '0; st.rd = '0;
      end
      default: ;
    endcase
    e = st;
    e.stall = exp_stall;
    e.idx = vec_idx;
    vec_idx++;
    sb.push_back(e);
    ov_ra_en = 1'b0; ov_rb_en = 1'b0;
  endtask

  task automatic chk(input string name, input int idx, input logic [NB_DATA-1:0] act,
                     input logic [NB_DATA-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
    end
  endtask

  // Driver
  initial begin
    cur = '{reset: 1'b1, enable: 1'b1, flush: 1'b0, valid: 1'b0, wb_we: 1'b0,
            ra: '0, rb: '0, imm: '0, pc4: '0, wb_data: '0,
            rs: '0, rt: '0, rd: '0, wb_addr: '0, ctrl: '0};
    st = '{idx: 0, stall: 1'b0, valid: 1'b0, chk_data: 1'b1, ra: '0, rb: '0, imm: '0,
           pc4: '0, rs: '0, rt: '0, rd: '0, ctrl: '0};
    apply();
    repeat (2) @(posedge i_clock);

    // Capture, then reset over a valid capture, then capture again
    cur.reset = 0; cur.valid = 1; cur.ra = 32'h11; cur.rb = 32'h22; cur.imm = 32'hFFFF_FFFC;
    cur.pc4 = 32'h100; cur.ctrl = 12'h001; cur.rs = 1; cur.rt = 2; cur.rd = 3;
    step(CAP, 0);
    cur.reset = 1; cur.ra = 32'h33;
    step(RST, 0);
    cur.reset = 0; cur.ra = 32'h11;
    step(CAP, 0);

    // Load-use: load rt=5, consumer rs=5 stalls once then captures
    cur.ctrl = 12'h00A; cur.rs = 6; cur.rt = 5; cur.rd = 0; cur.ra = 32'h55; cur.rb = 32'h66; cur.pc4 = 32'h104;
    step(CAP, 0);
    cur.ctrl = 12'h001; cur.rs = 5; cur.rt = 7; cur.rd = 9; cur.ra = 32'h77; cur.rb = 32'h88; cur.pc4 = 32'h108;
    step(BUB, 1);
    step(CAP, 0);

    // Load to r0 never hazards
    cur.ctrl = 12'h00A; cur.rs = 1; cur.rt = 0; cur.ra = 32'h91; cur.pc4 = 32'h10C;
    step(CAP, 0);
    cur.ctrl = 12'h001; cur.rs = 0; cur.rt = 3; cur.ra = 32'h92; cur.pc4 = 32'h110;
    step(CAP, 0);

    // Flush beats the hazard
    cur.ctrl = 12'h00A; cur.rs = 2; cur.rt = 5; cur.ra = 32'hA1; cur.pc4 = 32'h114;
    step(CAP, 0);
    cur.ctrl = 12'h001; cur.rs = 9; cur.rt = 5; cur.ra = 32'hA2; cur.pc4 = 32'h118; cur.flush = 1;
    step(BUB, 0);
    cur.flush = 0;
    step(CAP, 0);

    // Back-to-back loads, each stalls at most once
    cur.ctrl = 12'h00A; cur.rs = 1; cur.rt = 6; cur.ra = 32'hB1; cur.pc4 = 32'h11C;
    step(CAP, 0);
    cur.rs = 6; cur.rt = 8; cur.ra = 32'hB2; cur.pc4 = 32'h120;
    step(BUB, 1);
    step(CAP, 0);
    cur.ctrl = 12'h001; cur.rs = 8; cur.rt = 1; cur.ra = 32'hB3; cur.pc4 = 32'h124;
    step(BUB, 1);
    step(CAP, 0);

    // Debug freeze with a live hazard, then release
    cur.ctrl = 12'h00A; cur.rs = 0; cur.rt = 4; cur.ra = 32'hC1; cur.pc4 = 32'h128;
    step(CAP, 0);
    cur.enable = 0; cur.ctrl = 12'h001; cur.rs = 4; cur.rt = 1; cur.ra = 32'hAAAA;
    step(HOLD, 1);
    cur.ra = 32'hBBBB; cur.imm = 32'h5;
    step(HOLD, 1);
    cur.rs = 3; cur.ra = 32'hCCCC; cur.pc4 = 32'h200;
    step(HOLD, 0);
    cur.enable = 1;
    step(CAP, 0);

    // Invalid IF/ID slot gives a bubble
    cur.valid = 0;
    step(BUB, 0);

    // Reset overrides a pending stall
    cur.valid = 1; cur.ctrl = 12'h00A; cur.rs = 2; cur.rt = 5; cur.ra = 32'hD1;
    step(CAP, 0);
    cur.reset = 1; cur.ctrl = 12'h001; cur.rs = 5; cur.rt = 7; cur.ra = 32'hD2;
    step(RST, 1);
    cur.reset = 0;
    step(CAP, 0);

    // Writeback bypass onto ra, address-zero guard, bypass onto rb
    cur.wb_we = 1; cur.wb_addr = 4; cur.wb_data = 32'hDEAD;
    cur.rs = 4; cur.rt = 2; cur.ra = 32'h1; cur.rb = 32'h2;
    ov_ra_en = 1; ov_ra = BYP ? 32'hDEAD : 32'h1;
    step(CAP, 0);
    cur.wb_addr = 0; cur.rs = 0;
    step(CAP, 0);
    cur.wb_addr = 2; cur.rs = 1; cur.rt = 2;
    ov_rb_en = 1; ov_rb = BYP ? 32'hDEAD : 32'h2;
    step(CAP, 0);
    cur.wb_we = 0;
    drv_done = 1'b1;
  end

  // Monitor: stall is checked in the cycle the vector is applied, registers one cycle later
  initial begin
    exp_t pend;
    bit   pending = 1'b0;
    int   drain = 0;
    while (1) begin
      @(negedge i_clock);
      if (pending) begin
        chk("o_valid", pend.idx, NB_DATA'(o_valid), NB_DATA'(pend.valid));
        chk("o_ctrl", pend.idx, NB_DATA'(o_ctrl), NB_DATA'(pend.ctrl));
        if (pend.chk_data) begin
          chk("o_data_ra", pend.idx, o_data_ra, pend.ra);
          chk("o_data_rb", pend.idx, o_data_rb, pend.rb);
          chk("o_imm", pend.idx, o_imm, pend.imm);
          chk("o_pc4", pend.idx, o_pc4, pend.pc4);
          chk("o_rs", pend.idx, NB_DATA'(o_rs), NB_DATA'(pend.rs));
          chk("o_rt", pend.idx, NB_DATA'(o_rt), NB_DATA'(pend.rt));
          chk("o_rd", pend.idx, NB_DATA'(o_rd), NB_DATA'(pend.rd));
        end
        pending = 1'b0;
      end
      if (sb.size() > 0) begin
        pend = sb.pop_front();
        chk("o_stall", pend.idx, NB_DATA'(o_stall), NB_DATA'(pend.stall));
        pending = 1'b1;
      end
      if (drv_done && !pending && sb.size() == 0) break;
      if (drv_done) begin
        drain++;
        if (drain > 20) begin
          checks++;
          errors++;
          $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
          break;
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
